// File: rtl/stack_pkg.sv
// stack_pkg: shared state encoding, geometry defaults and popcount for the blockstacker round controller.
package stack_pkg;
  localparam int COLS_DEF = 8;
  localparam int ROWS_DEF = 15;
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SLIDE   = 3'd1;
  localparam logic [2:0] S_PLACE   = 3'd2;
  localparam logic [2:0] S_ADVANCE = 3'd3;
  localparam logic [2:0] S_LOST    = 3'd4;
  localparam logic [2:0] S_WON     = 3'd5;
  function automatic logic [5:0] popcount(input logic [31:0] v);
    popcount = '0;
    for (int i = 0; i < 32; i++) popcount = popcount + 6'(v[i]);
  endfunction
endpackage

// File: rtl/stack_round_ctrl_if.sv
// stack_round_ctrl_if: player/level inputs and row/framebuffer outputs of the round controller.
interface stack_round_ctrl_if import stack_pkg::*; #(
  parameter int COLS = COLS_DEF,
  parameter int SW   = $clog2(COLS + 1)
);
  logic            go;
  logic [3:0]      speed;
  logic [COLS-1:0] row_mask;
  logic [3:0]      row_index;
  logic [SW-1:0]   seg_width;
  logic            next_signal;
  logic            place_we;
  logic [3:0]      place_row;
  logic [COLS-1:0] place_mask;
  logic            game_over;
  logic            win;
  modport master (
    output go, speed,
    input  row_mask, row_index, seg_width, next_signal, place_we, place_row, place_mask, game_over, win
  );
  modport slave (
    input  go, speed,
    output row_mask, row_index, seg_width, next_signal, place_we, place_row, place_mask, game_over, win
  );
endinterface

// File: rtl/move_tick_gen.sv
// move_tick_gen: slide-step divider whose period shrinks with speed level, clamped at MIN_DIV.
module move_tick_gen #(
  parameter int BASE_DIV = 16,
  parameter int DIV_STEP = 1,
  parameter int MIN_DIV  = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clr,
  input  logic [3:0] speed,
  output logic       tick
);
  logic        [15:0] cnt;
  logic signed [31:0] spd, raw, div;
  always_comb begin
    spd = (speed == 4'd0) ? 32'sd1 : $signed({28'd0, speed});
    raw = BASE_DIV - (spd - 1) * DIV_STEP;
    div = (raw < MIN_DIV) ? MIN_DIV : raw;
  end
  // >= rather than == so a speed-up mid-count never strands the counter past the new period
  assign tick = !clr && ($signed({16'd0, cnt}) >= div - 1);
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) cnt <= '0;
    else cnt <= (clr || tick) ? '0 : cnt + 16'd1;
endmodule

// File: rtl/stack_round_ctrl.sv
// stack_round_ctrl: sequences one blockstacker game -- slide, place, trim to overlap, advance or end.
module stack_round_ctrl import stack_pkg::*; #(
  parameter int COLS     = COLS_DEF,
  parameter int ROWS     = ROWS_DEF,
  parameter int INIT_W   = 3,
  parameter int BASE_DIV = 16,
  parameter int DIV_STEP = 1,
  parameter int MIN_DIV  = 2
) (
  input logic               clk,
  input logic               resetn,
  stack_round_ctrl_if.slave bus
);
  localparam int SW = $clog2(COLS + 1);
  logic [2:0]      state;
  logic [SW-1:0]   width, pos, lim;
  logic            dir_left, tick, adv;
  logic [COLS-1:0] prev_mask, frozen, shaped, overlap;
  logic [3:0]      row;
  move_tick_gen #(.BASE_DIV(BASE_DIV), .DIV_STEP(DIV_STEP), .MIN_DIV(MIN_DIV)) u_tick (
    .clk(clk), .resetn(resetn), .clr(state != S_SLIDE), .speed(bus.speed), .tick(tick)
  );
  assign lim     = SW'(COLS) - width;
  assign shaped  = ({COLS{1'b1}} >> lim) << pos;
  assign overlap = frozen & prev_mask;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state     <= S_IDLE;
      width     <= '0;
      pos       <= '0;
      dir_left  <= 1'b0;
      row       <= '0;
      prev_mask <= '1;
      frozen    <= '0;
    end else
      case (state)
        S_SLIDE:
          if (bus.go) begin
            frozen <= shaped;
            state  <= S_PLACE;
          end else if (tick) begin
            if (!dir_left) begin
              if (pos < lim) pos <= pos + 1'b1;
              else begin
                dir_left <= 1'b1;
                if (pos != '0) pos <= pos - 1'b1;
              end
            end else begin
              if (pos != '0) pos <= pos - 1'b1;
              else begin
                dir_left <= 1'b0;
                if (pos < lim) pos <= pos + 1'b1;
              end
            end
          end
        S_PLACE:
          if (overlap == '0) state <= S_LOST;
          else begin
            prev_mask <= overlap;
            width     <= SW'(popcount(32'(overlap)));
            state     <= S_ADVANCE;
          end
        S_ADVANCE:
          if (row == 4'(ROWS - 1)) state <= S_WON;
          else begin
            row      <= row + 4'd1;
            pos      <= '0;
            dir_left <= 1'b0;
            state    <= S_SLIDE;
          end
        default:
          if (bus.go) begin
            state     <= S_SLIDE;
            row       <= '0;
            width     <= SW'(INIT_W);
            pos       <= '0;
            dir_left  <= 1'b0;
            prev_mask <= '1;
          end
      endcase
  assign adv             = state == S_ADVANCE;
  assign bus.row_mask    = (state == S_SLIDE) ? shaped :
                           (state == S_PLACE || adv || state == S_LOST) ? frozen : '0;
  assign bus.row_index   = row;
  assign bus.seg_width   = width;
  assign bus.next_signal = adv;
  assign bus.place_we    = adv;
  assign bus.place_row   = adv ? row : '0;
  assign bus.place_mask  = adv ? prev_mask : '0;
  assign bus.game_over   = state == S_LOST;
  assign bus.win         = state == S_WON;
endmodule

// File: tb/tb_stack_round_ctrl.sv
// tb_stack_round_ctrl: directed scenarios plus randomized games against a behavioural game model.
module tb_stack_round_ctrl;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;
  stack_round_ctrl_if bus();
  stack_round_ctrl dut (.clk(clk), .resetn(resetn), .bus(bus));
  int n_cmp = 0, n_err = 0;
  localparam int P_IDLE = 0, P_SLIDE = 1, P_PLACE = 2, P_ADV = 3, P_LOST = 4, P_WON = 5;
  int m_phase, m_row, m_w, m_pos, m_dir, m_cnt;
  logic [7:0] m_prev, m_frozen;

  function automatic int period(input logic [3:0] s);
    int spd = (s == 4'd0) ? 1 : int'(s);
    int d = 16 - (spd - 1);
    return (d < 2) ? 2 : d;
  endfunction

  function automatic logic [7:0] exp_mask();
    logic [7:0] seg = 8'((1 << m_w) - 1);
    if (m_phase == P_SLIDE) return seg << m_pos;
    if (m_phase == P_PLACE || m_phase == P_ADV || m_phase == P_LOST) return m_frozen;
    return 8'h00;
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_row = 0; m_w = 0; m_pos = 0; m_dir = 1; m_cnt = 0;
    m_prev = 8'hFF; m_frozen = 8'h00;
  endtask

  task automatic model_edge(input logic g, input logic [3:0] s);
    int nxt;
    logic [7:0] ov;
    case (m_phase)
      P_SLIDE:
        if (g) begin
          m_frozen = exp_mask();
          m_phase = P_PLACE;
        end else if (m_cnt == period(s) - 1) begin
          m_cnt = 0;
          nxt = m_pos + m_dir;
          if (nxt < 0 || nxt > 8 - m_w) begin
            m_dir = -m_dir;
            nxt = m_pos + m_dir;
            if (nxt < 0 || nxt > 8 - m_w) nxt = m_pos;
          end
          m_pos = nxt;
        end else m_cnt++;
      P_PLACE: begin
        ov = m_frozen & m_prev;
        if (ov == 8'h00) m_phase = P_LOST;
        else begin
          m_prev = ov; m_w = $countones(ov); m_phase = P_ADV;
        end
      end
      P_ADV:
        if (m_row == 14) m_phase = P_WON;
        else begin
          m_row++; m_pos = 0; m_dir = 1; m_cnt = 0; m_phase = P_SLIDE;
        end
      default:
        if (g) begin
          m_phase = P_SLIDE; m_row = 0; m_w = 3; m_pos = 0; m_dir = 1; m_cnt = 0; m_prev = 8'hFF;
        end
    endcase
  endtask

  task automatic step(input logic g, input logic [3:0] s);
    bus.go = g;
    bus.speed = s;
    @(posedge clk);
    #1;
    model_edge(g, s);
    bus.go = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    bus.go = 1'b0;
    bus.speed = 4'd1;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    model_reset();
  endtask

  task automatic wait_change(input logic [3:0] s, input int bound, output int n);
    logic [7:0] last = bus.row_mask;
    n = 0;
    while (bus.row_mask == last && n < bound) begin
      step(1'b0, s);
      n++;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.go = 1'b0;
    bus.speed = 4'd0;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.row_mask, bus.row_index, bus.seg_width, bus.next_signal, bus.place_we, bus.place_row,
         bus.place_mask, bus.game_over, bus.win} !== 35'd0) begin
      n_err++;
      $display("FAIL reset_outputs: mask=%h row=%0d w=%0d ns=%b we=%b prow=%0d pmask=%h go=%b win=%b, all required 0",
               bus.row_mask, bus.row_index, bus.seg_width, bus.next_signal, bus.place_we, bus.place_row,
               bus.place_mask, bus.game_over, bus.win);
    end
    do_reset();
  endtask

  task automatic test_slide_rate();
    logic [3:0] sp[3] = '{4'd1, 4'd0, 4'd15};
    int ex[3] = '{16, 16, 2};
    int n;
    do_reset();
    step(1'b1, 4'd1);
    n_cmp++;
    if (bus.row_mask !== 8'h07) begin
      n_err++;
      $display("FAIL start_mask: got %h, want 07", bus.row_mask);
    end
    for (int i = 0; i < 3; i++) begin
      wait_change(sp[i], 40, n);
      wait_change(sp[i], 40, n);
      n_cmp++;
      if (n !== ex[i]) begin
        n_err++;
        $display("FAIL slide_period speed=%0d: got %0d clocks, want %0d", sp[i], n, ex[i]);
      end
    end
  endtask

  task automatic test_bounce();
    logic [7:0] ex[12] = '{8'h07, 8'h0E, 8'h1C, 8'h38, 8'h70, 8'hE0, 8'h70, 8'h38, 8'h1C, 8'h0E, 8'h07, 8'h0E};
    int n;
    do_reset();
    step(1'b1, 4'd15);
    for (int i = 1; i < 12; i++) begin
      wait_change(4'd15, 10, n);
      n_cmp++;
      if (bus.row_mask !== ex[i]) begin
        n_err++;
        $display("FAIL bounce[%0d]: got %h, want %h", i, bus.row_mask, ex[i]);
      end
    end
  endtask

  task automatic test_place_trim();
    int n;
    bit ns_seen;
    do_reset();
    step(1'b1, 4'd1);
    step(1'b1, 4'd1);
    step(1'b0, 4'd1);
    n_cmp++;
    if ({bus.next_signal, bus.place_we, bus.place_row, bus.place_mask} !== {1'b1, 1'b1, 4'd0, 8'h07}) begin
      n_err++;
      $display("FAIL place_row0: ns=%b we=%b row=%0d mask=%h, want 1 1 0 07",
               bus.next_signal, bus.place_we, bus.place_row, bus.place_mask);
    end
    step(1'b0, 4'd1);
    n_cmp++;
    if ({bus.row_index, bus.seg_width, bus.row_mask, bus.place_we} !== {4'd1, 4'd3, 8'h07, 1'b0}) begin
      n_err++;
      $display("FAIL row1_start: row=%0d w=%0d mask=%h we=%b, want 1 3 07 0",
               bus.row_index, bus.seg_width, bus.row_mask, bus.place_we);
    end
    n = 0;
    while (bus.row_mask !== 8'h1C && n < 100) begin
      step(1'b0, 4'd1);
      n++;
    end
    n_cmp++;
    if (bus.row_mask !== 8'h1C) begin
      n_err++;
      $display("FAIL reach_pos2: got %h, want 1c", bus.row_mask);
    end
    step(1'b1, 4'd1);
    step(1'b0, 4'd1);
    n_cmp++;
    if ({bus.place_we, bus.place_row, bus.place_mask} !== {1'b1, 4'd1, 8'h04}) begin
      n_err++;
      $display("FAIL trim_place: we=%b row=%0d mask=%h, want 1 1 04", bus.place_we, bus.place_row, bus.place_mask);
    end
    step(1'b0, 4'd1);
    n_cmp++;
    if ({bus.seg_width, bus.row_index, bus.row_mask} !== {4'd1, 4'd2, 8'h01}) begin
      n_err++;
      $display("FAIL trim_width: w=%0d row=%0d mask=%h, want 1 2 01", bus.seg_width, bus.row_index, bus.row_mask);
    end
    step(1'b1, 4'd1);
    ns_seen = bus.next_signal | bus.place_we;
    step(1'b0, 4'd1);
    ns_seen |= bus.next_signal | bus.place_we;
    n_cmp++;
    if ({bus.game_over, bus.win, ns_seen, bus.row_mask} !== {1'b1, 1'b0, 1'b0, 8'h01}) begin
      n_err++;
      $display("FAIL lose: over=%b win=%b pulse=%b mask=%h, want 1 0 0 01", bus.game_over, bus.win, ns_seen, bus.row_mask);
    end
  endtask

  task automatic test_win();
    int pulses = 0;
    do_reset();
    step(1'b1, 4'd15);
    for (int r = 0; r < 15; r++) begin
      step(1'b1, 4'd15);
      step(1'b0, 4'd15);
      if (bus.next_signal && bus.place_row == 4'(r)) pulses++;
      step(1'b0, 4'd15);
    end
    n_cmp++;
    if ({pulses[4:0], bus.win, bus.game_over, bus.row_mask} !== {5'd15, 1'b1, 1'b0, 8'h00}) begin
      n_err++;
      $display("FAIL win: pulses=%0d win=%b over=%b mask=%h, want 15 1 0 00", pulses, bus.win, bus.game_over, bus.row_mask);
    end
    step(1'b1, 4'd15);
    n_cmp++;
    if ({bus.win, bus.row_index, bus.seg_width, bus.row_mask} !== {1'b0, 4'd0, 4'd3, 8'h07}) begin
      n_err++;
      $display("FAIL restart: win=%b row=%0d w=%0d mask=%h, want 0 0 3 07", bus.win, bus.row_index, bus.seg_width, bus.row_mask);
    end
  endtask

  task automatic test_go_tick();
    do_reset();
    step(1'b1, 4'd1);
    repeat (16) step(1'b0, 4'd1);
    n_cmp++;
    if (bus.row_mask !== 8'h0E) begin
      n_err++;
      $display("FAIL first_tick: got %h, want 0e", bus.row_mask);
    end
    do_reset();
    step(1'b1, 4'd1);
    repeat (15) step(1'b0, 4'd1);
    step(1'b1, 4'd1);
    n_cmp++;
    if (bus.row_mask !== 8'h07) begin
      n_err++;
      $display("FAIL go_tick_freeze: got %h, want 07", bus.row_mask);
    end
    step(1'b0, 4'd1);
    n_cmp++;
    if (bus.place_mask !== 8'h07) begin
      n_err++;
      $display("FAIL go_tick_place: got %h, want 07", bus.place_mask);
    end
  endtask

  task automatic test_reset_in_place();
    bit we_seen = 1'b0;
    do_reset();
    step(1'b1, 4'd1);
    step(1'b1, 4'd1);
    #2 resetn = 1'b0;
    #1;
    n_cmp++;
    if ({bus.row_mask, bus.row_index, bus.seg_width, bus.next_signal, bus.place_we, bus.place_row,
         bus.place_mask, bus.game_over, bus.win} !== 35'd0) begin
      n_err++;
      $display("FAIL reset_in_place: mask=%h row=%0d w=%0d we=%b, all required 0",
               bus.row_mask, bus.row_index, bus.seg_width, bus.place_we);
    end
    repeat (3) begin
      @(posedge clk);
      #1 we_seen |= bus.place_we | bus.next_signal;
    end
    resetn = 1'b1;
    n_cmp++;
    if (we_seen !== 1'b0) begin
      n_err++;
      $display("FAIL reset_no_write: pulse seen=%b, want 0", we_seen);
    end
  endtask

  task automatic test_random();
    logic [3:0] spd = 4'd1;
    logic g;
    do_reset();
    for (int c = 0; c < 5000; c++) begin
      if (m_phase == P_IDLE || m_phase == P_LOST || m_phase == P_WON) spd = 4'($urandom_range(0, 15));
      if (m_phase == P_SLIDE && (exp_mask() & m_prev) == exp_mask()) g = ($urandom_range(0, 1) == 0);
      else g = (m_phase == P_SLIDE) ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 5) == 0);
      step(g, spd);
      n_cmp += 9;
      if (bus.row_mask !== exp_mask()) begin
        n_err++; $display("FAIL rnd_mask c=%0d: got %h, want %h", c, bus.row_mask, exp_mask());
      end
      if (bus.row_index !== 4'(m_row)) begin
        n_err++; $display("FAIL rnd_row c=%0d: got %0d, want %0d", c, bus.row_index, m_row);
      end
      if (bus.seg_width !== 4'(m_w)) begin
        n_err++; $display("FAIL rnd_width c=%0d: got %0d, want %0d", c, bus.seg_width, m_w);
      end
      if (bus.next_signal !== (m_phase == P_ADV)) begin
        n_err++; $display("FAIL rnd_next c=%0d: got %b, want %b", c, bus.next_signal, m_phase == P_ADV);
      end
      if (bus.place_we !== (m_phase == P_ADV)) begin
        n_err++; $display("FAIL rnd_we c=%0d: got %b, want %b", c, bus.place_we, m_phase == P_ADV);
      end
      if (bus.place_row !== ((m_phase == P_ADV) ? 4'(m_row) : 4'd0)) begin
        n_err++; $display("FAIL rnd_prow c=%0d: got %0d, want %0d", c, bus.place_row, (m_phase == P_ADV) ? m_row : 0);
      end
      if (bus.place_mask !== ((m_phase == P_ADV) ? m_prev : 8'h00)) begin
        n_err++; $display("FAIL rnd_pmask c=%0d: got %h, want %h", c, bus.place_mask, (m_phase == P_ADV) ? m_prev : 8'h00);
      end
      if (bus.game_over !== (m_phase == P_LOST)) begin
        n_err++; $display("FAIL rnd_over c=%0d: got %b, want %b", c, bus.game_over, m_phase == P_LOST);
      end
      if (bus.win !== (m_phase == P_WON)) begin
        n_err++; $display("FAIL rnd_win c=%0d: got %b, want %b", c, bus.win, m_phase == P_WON);
      end
    end
  endtask

  initial begin
    bus.go = 1'b0;
    bus.speed = 4'd1;
    model_reset();
    test_reset();
    test_slide_rate();
    test_bounce();
    test_place_trim();
    test_win();
    test_go_tick();
    test_reset_in_place();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
